// File: rtl/h264_pkg.sv
// Shared definitions for the H.264 coefficient dequantiser.
//
// Contents:
//   ZinW, WoutW, QpW, ScaleW  - datapath widths
//   QpMax                     - largest QP the rescaler accepts; larger values clamp here
//   pos_class_e               - coefficient position class (A, B, C)
//   LevelScaleA/B/C           - levelscale table, indexed by QP mod 6
//   zig_class()               - maps the 4-bit position counter to a position class
package h264_pkg;

    localparam int unsigned ZinW   = 12;
    localparam int unsigned WoutW  = 16;
    localparam int unsigned QpW    = 6;
    localparam int unsigned ScaleW = 5;

    localparam logic [QpW-1:0] QpMax = 6'd51;

    typedef enum logic [1:0] {
        PosA,
        PosB,
        PosC
    } pos_class_e;

    localparam logic [ScaleW-1:0] LevelScaleA [6] = '{5'd10, 5'd11, 5'd13, 5'd14, 5'd16, 5'd18};
    localparam logic [ScaleW-1:0] LevelScaleB [6] = '{5'd16, 5'd18, 5'd20, 5'd23, 5'd25, 5'd29};
    localparam logic [ScaleW-1:0] LevelScaleC [6] = '{5'd13, 5'd14, 5'd16, 5'd18, 5'd20, 5'd23};

    function automatic pos_class_e zig_class(input logic [3:0] zig);
        pos_class_e cls;
        case (zig)
            4'd0, 4'd3, 4'd5, 4'd11:   cls = PosA;
            4'd4, 4'd10, 4'd12, 4'd15: cls = PosB;
            default:                   cls = PosC;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/h264levelscale.sv
// Levelscale lookup: combinational map from (QP mod 6, position class) to the
// rescale multiplier v.
//
// Ports:
//   qm_i        - QP mod 6 (0..5); other codes return 0
//   pos_class_i - coefficient position class
//   scale_o     - levelscale multiplier v
module h264levelscale
    import h264_pkg::*;
(
    input  logic [2:0]        qm_i,
    input  pos_class_e        pos_class_i,
    output logic [ScaleW-1:0] scale_o
);

    always_comb begin
        scale_o = '0;
        if (qm_i < 3'd6) begin
            unique case (pos_class_i)
                PosA:    scale_o = LevelScaleA[qm_i];
                PosB:    scale_o = LevelScaleB[qm_i];
                PosC:    scale_o = LevelScaleC[qm_i];
                default: scale_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/h264_dequantise.sv
// H.264 4x4 coefficient dequantiser: rescales one quantised level per cycle
// as W = ZIN * v * 2^qd (doubled for DC), saturated to 16 bits.
//
// Ports:
//   CLK    - clock, rising edge
//   RESETN - synchronous active-low reset
//   ENABLE - ZIN carries a valid coefficient this cycle
//   DCCI   - ZIN carries a DC coefficient (qualified by ENABLE)
//   QP     - quantiser parameter, sampled with each coefficient
//   ZIN    - signed quantised level
//   VALID  - WOUT carries a result (3 cycles after ENABLE)
//   DCCO   - the result on WOUT is a DC result
//   WOUT   - signed rescaled coefficient; held while VALID is low
//
// Pipeline: S1 registers ZIN, v, qd and the DC flag; S2 multiplies ZIN * v;
// S3 shifts by qd (+1 for DC) and saturates into WOUT.
module h264_dequantise
    import h264_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    ENABLE,
    input  logic                    DCCI,
    input  logic [QpW-1:0]          QP,
    input  logic signed [ZinW-1:0]  ZIN,
    output logic                    VALID,
    output logic                    DCCO,
    output logic signed [WoutW-1:0] WOUT
);

    // 12-bit level times 5-bit unsigned scale needs 17 bits; one spare keeps it simple.
    localparam int unsigned ProdW = 18;
    // Product shifted by up to 9 (qd=8 plus the DC doubling).
    localparam int unsigned WideW = 27;

    localparam logic signed [WideW-1:0] SatHi = WideW'(32767);
    localparam logic signed [WideW-1:0] SatLo = -WideW'(32767);

    // ------------------------------------------------------------------
    // Position counter and per-coefficient parameter derivation
    // ------------------------------------------------------------------
    logic [3:0]        zig_q, zig_d;
    logic [QpW-1:0]    qp_clamp;
    logic [3:0]        qd;
    logic [2:0]        qm;
    pos_class_e        pos_class;
    logic [ScaleW-1:0] scale;

    always_comb begin
        // A gap or a DC coefficient restarts the scan at position 15.
        if (!ENABLE || DCCI) begin
            zig_d = 4'd15;
        end else begin
            zig_d = zig_q - 4'd1;
        end
    end

    always_comb begin
        qp_clamp  = (QP > QpMax) ? QpMax : QP;
        qd        = 4'(qp_clamp / 6'd6);
        qm        = 3'(qp_clamp % 6'd6);
        // DC always uses the class-A multiplier, whatever zig says.
        pos_class = DCCI ? PosA : zig_class(zig_q);
    end

    h264levelscale u_levelscale (
        .qm_i        (qm),
        .pos_class_i (pos_class),
        .scale_o     (scale)
    );

    // ------------------------------------------------------------------
    // S1: capture level, multiplier, shift and DC flag
    // ------------------------------------------------------------------
    logic                   s1_valid_q;
    logic                   s1_dc_q;
    logic signed [ZinW-1:0] s1_zin_q;
    logic [ScaleW-1:0]      s1_scale_q;
    logic [3:0]             s1_qd_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            zig_q      <= 4'd15;
            s1_valid_q <= 1'b0;
            s1_dc_q    <= 1'b0;
            s1_zin_q   <= '0;
            s1_scale_q <= '0;
            s1_qd_q    <= '0;
        end else begin
            zig_q      <= zig_d;
            s1_valid_q <= ENABLE;
            s1_dc_q    <= ENABLE & DCCI;
            if (ENABLE) begin
                s1_zin_q   <= ZIN;
                s1_scale_q <= scale;
                s1_qd_q    <= qd;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: multiply
    // ------------------------------------------------------------------
    logic                    s2_valid_q;
    logic                    s2_dc_q;
    logic signed [ProdW-1:0] s2_prod_q, s2_prod_d;
    logic [3:0]              s2_shift_q, s2_shift_d;

    always_comb begin
        s2_prod_d  = $signed({{(ProdW-ZinW){s1_zin_q[ZinW-1]}}, s1_zin_q})
                   * $signed({{(ProdW-ScaleW){1'b0}}, s1_scale_q});
        s2_shift_d = s1_qd_q + {3'b000, s1_dc_q};
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            s2_valid_q <= 1'b0;
            s2_dc_q    <= 1'b0;
            s2_prod_q  <= '0;
            s2_shift_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_dc_q    <= s1_dc_q;
            if (s1_valid_q) begin
                s2_prod_q  <= s2_prod_d;
                s2_shift_q <= s2_shift_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: shift and saturate
    // ------------------------------------------------------------------
    logic                    s3_valid_q;
    logic                    s3_dc_q;
    logic signed [WoutW-1:0] wout_q, wout_d;
    logic signed [WideW-1:0] wide;

    always_comb begin
        wide = $signed({{(WideW-ProdW){s2_prod_q[ProdW-1]}}, s2_prod_q}) <<< s2_shift_q;
        // Symmetric clamp: -32768 is never produced.
        if (wide > SatHi) begin
            wout_d = 16'sh7FFF;
        end else if (wide < SatLo) begin
            wout_d = 16'sh8001;
        end else begin
            wout_d = wide[WoutW-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            s3_valid_q <= 1'b0;
            s3_dc_q    <= 1'b0;
            wout_q     <= '0;
        end else begin
            s3_valid_q <= s2_valid_q;
            s3_dc_q    <= s2_dc_q;
            if (s2_valid_q) begin
                wout_q <= wout_d;
            end
        end
    end

    always_comb begin
        VALID = s3_valid_q;
        DCCO  = s3_dc_q;
        WOUT  = wout_q;
    end

endmodule

// File: tb/tb_h264_dequantise.sv
// Self-checking bench for h264_dequantise. Every cycle of stimulus pushes the
// expected VALID/DCCO/WOUT for three cycles later into a scoreboard queue; a
// checker process pops and compares one entry per cycle.
module tb_h264_dequantise;

    logic              clk;
    logic              RESETN;
    logic              ENABLE;
    logic              DCCI;
    logic [5:0]        QP;
    logic signed [11:0] ZIN;
    logic              VALID;
    logic              DCCO;
    logic signed [15:0] WOUT;

    h264_dequantise dut (
        .CLK    (clk),
        .RESETN (RESETN),
        .ENABLE (ENABLE),
        .DCCI   (DCCI),
        .QP     (QP),
        .ZIN    (ZIN),
        .VALID  (VALID),
        .DCCO   (DCCO),
        .WOUT   (WOUT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        bit          valid;
        bit          dc;
        logic [15:0] w;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          vectors = 0;
    int          fails = 0;
    int          zig_m = 15;
    logic [15:0] last_w = '0;

    int ls_a[6] = '{10, 11, 13, 14, 16, 18};
    int ls_b[6] = '{16, 18, 20, 23, 25, 29};
    int ls_c[6] = '{13, 14, 16, 18, 20, 23};

    int req27[16] = '{16, 13, 13, 16, 10, 16, 13, 13, 13, 13, 10, 16, 10, 13, 13, 10};

    function automatic logic [15:0] model_w(input bit dc, input int qp, input int zin,
                                            input int zig);
        int     q, qd, qm, v;
        longint w;
        q  = (qp > 51) ? 51 : qp;
        qd = q / 6;
        qm = q % 6;
        if (dc || zig inside {0, 3, 5, 11}) v = ls_a[qm];
        else if (zig inside {4, 10, 12, 15}) v = ls_b[qm];
        else v = ls_c[qm];
        w = longint'(zin) * longint'(v) * (longint'(1) << qd);
        if (dc) w = w * 2;
        if (w > 32767) return 16'h7FFF;
        if (w < -32767) return 16'h8001;
        return 16'(w);
    endfunction

    // One stimulus cycle; use_exp selects a hand-computed expectation over the model.
    task automatic step(input bit rst, input bit en, input bit dc, input int qp, input int zin,
                        input bit use_exp, input int expw);
        exp_t e;
        exp_t t;
        @(negedge clk);
        RESETN = rst;
        ENABLE = en;
        DCCI   = dc;
        QP     = 6'(qp);
        ZIN    = 12'(zin);
        if (!rst) begin
            // Everything in flight is dropped; outputs read zero until new data arrives.
            foreach (sb[i]) begin
                if (sb[i].due > cyc) begin
                    t       = sb[i];
                    t.valid = 1'b0;
                    t.dc    = 1'b0;
                    t.w     = '0;
                    sb[i]   = t;
                end
            end
            last_w = '0;
            zig_m  = 15;
            e = '{due: cyc + 3, valid: 1'b0, dc: 1'b0, w: 16'h0000};
        end else begin
            if (en) begin
                last_w = use_exp ? 16'(expw) : model_w(dc, qp, zin, zig_m);
            end
            e = '{due: cyc + 3, valid: en, dc: en & dc, w: last_w};
            if (!en || dc) zig_m = 15;
            else zig_m = (zig_m == 0) ? 15 : zig_m - 1;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    // Checker: compares the scoreboard head due this cycle, 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                vectors++;
                assert (VALID === e.valid) else begin
                    fails++;
                    $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, VALID, e.valid);
                end
                assert (DCCO === e.dc) else begin
                    fails++;
                    $error("FAIL dcco cyc=%0d observed=%b expected=%b", cyc, DCCO, e.dc);
                end
                assert (WOUT === e.w) else begin
                    fails++;
                    $error("FAIL wout cyc=%0d observed=%0d expected=%0d", cyc, WOUT,
                           $signed(e.w));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETN = 1'b0;
        ENABLE = 1'b0;
        DCCI   = 1'b0;
        QP     = '0;
        ZIN    = '0;

        // Reset state
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        idle(2);

        // Full block at QP=0, unit level: raw levelscale pattern in scan order
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 0, 1, 1'b1, req27[i]);
        idle(2);

        // QP=28, -3 at the final position (zig=0)
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 28, i - 7, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 28, -3, 1'b1, -768);
        idle(1);

        // DC coefficient at QP=12
        step(1'b1, 1'b1, 1'b1, 12, 5, 1'b1, 400);
        idle(1);

        // Saturation at QP=51, class-B position
        step(1'b1, 1'b1, 1'b0, 51, 2047, 1'b1, 'h7FFF);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 51, -2048, 1'b1, 'h8001);
        step(1'b1, 1'b1, 1'b0, 60, 100, 1'b0, 0);
        idle(1);

        // One-cycle reset mid-block; next coefficient restarts at zig=15
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 20, 40 + i, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 20, 9, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 1, 1'b1, 16);

        // Enable gap after 5 coefficients restarts at zig=15
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 3, 1'b0, 0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 0, 1, 1'b1, 16);

        // Mixed random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 4095)) - 2048, 1'b0, 0);
        end

        idle(4);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL drain: observed=%0d pending expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
